mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one 32-bit memory port between the IF stage (instruction reads) and the MEM stage (data reads/writes).
//  Runs one access at a time. Data has priority over instructions, with a starvation guard so fetch still makes progress.
//  Rejects misaligned accesses locally and bounds every memory access with a timeout.
//  Sits between the pipeline fetch/MEM stages and the memory model / bus adapter.
// PARAMETERS
//  MAX_D_STREAK  4    consecutive D grants allowed while i_req is pending; the next grant is forced to I
//  TIMEOUT       64   cycles to wait for mem_ready before the access is aborted with err
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  i_req      in   1   instruction read request; held with i_addr stable until i_rvalid
//  i_addr     in   32  instruction byte address
//  i_rvalid   out  1   1-cycle pulse: i_rdata and i_err valid
//  i_rdata    out  32  fetched word (0 on error)
//  i_err      out  1   misaligned address or timeout; qualified by i_rvalid
//  d_req      in   1   data request; held with d_* stable until d_rvalid
//  d_we       in   1   1 = write, 0 = read
//  d_addr     in   32  data byte address
//  d_wdata    in   32  write data
//  d_wstrb    in   4   byte enables (writes only)
//  d_rvalid   out  1   1-cycle pulse: completion of the data access
//  d_rdata    out  32  read data (0 on writes and errors)
//  d_err      out  1   misaligned address or timeout; qualified by d_rvalid
//  mem_req    out  1   request to memory; held until mem_ready
//  mem_we     out  1   write enable to memory
//  mem_addr   out  32  word-aligned address to memory
//  mem_wdata  out  32  write data to memory
//  mem_wstrb  out  4   byte strobes to memory (0 on reads)
//  mem_ready  in   1   memory completes the access this cycle; mem_rdata is valid
//  mem_rdata  in   32  read data from memory
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, streak counter and timeout counter = 0.
//    Reset mid-access drops the access and emits no rvalid; mem_req is 0 on the cycle after rst.
//  FSM states: IDLE, BUSY_I, BUSY_D. All outputs are registered.
//  IDLE grant selection (sampled each cycle):
//    - d_req && !(i_req && streak==MAX_D_STREAK) -> grant D.
//    - else i_req -> grant I.
//    - else stay IDLE.
//  Misaligned grant (addr[1:0]!=0):
//    - No memory access is made; state stays IDLE.
//    - Next cycle: x_rvalid=1, x_err=1, x_rdata=0.
//  Aligned grant:
//    - At the edge, mem_req=1 and mem_addr/we/wdata/wstrb are latched; state goes to BUSY_I or BUSY_D.
//    - Grant to I forces mem_we=0 and mem_wstrb=0.
//  BUSY_x:
//    - mem_req stays 1 and mem_* stay stable. The timeout counter increments every cycle.
//    - mem_ready=1: at the edge, mem_req=0, x_rvalid=1, x_rdata=mem_rdata (0 if write), x_err=0, state goes to IDLE.
//    - Counter reaches TIMEOUT-1 with no mem_ready: mem_req=0, x_rvalid=1, x_err=1, x_rdata=0, state goes to IDLE.
//  Latency: req in cycle N, mem_req from N+1, rvalid in cycle M+1, where M is the first cycle with mem_ready=1.
//    Minimum is N+2.
//  rvalid cycle: FSM is already IDLE and samples requests. A requester still asserting req is treated as a new access.
//    Requesters must drop or update req in that cycle.
//  Never grants twice in one cycle. i_rvalid and d_rvalid are never high together.
//  Streak counter (saturates at MAX_D_STREAK):
//    - D grant while i_req=1: +1.
//    - Any I grant, or any cycle with i_req=0: cleared to 0.
//  mem_ready while IDLE is ignored.
// TESTING
//  1. I read 0x100, mem_ready fixed at 1, mem_rdata=0xDEADBEEF -> mem_req in N+1 only, i_rvalid with 0xDEADBEEF in N+2.
//  2. i_req and d_req in the same cycle -> D served first, then I. rvalid pulses never overlap.
//  3. d_req held continuously (back-to-back), i_req held, MAX_D_STREAK=4 -> 4 D grants, then 1 I grant, then D resumes.
//  4. d_addr=0x102 -> d_rvalid=1 and d_err=1 next cycle, mem_req never asserted.
//  5. mem_ready tied 0, TIMEOUT=64 -> mem_req high for exactly 64 cycles, then i_rvalid=1 and i_err=1 with rdata=0.
//  6. rst=1 while in BUSY_D -> no d_rvalid; mem_req=0 and FSM=IDLE the cycle after rst.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every handshake/bus signal around the memory port arbiter:
//   the IF-stage read channel (i_*), the MEM-stage data channel (d_*)
//   and the shared memory port (mem_*).
//
//   Modports:
//     slave  - the arbiter's view. It takes requests from the pipeline,
//              returns completions, drives the memory port and takes
//              mem_ready/mem_rdata.
//     master - the surrounding environment: pipeline stages plus the
//              memory model or bus adapter.
//
//   Signals:
//     i_req, i_addr[31:0]                 instruction read request
//     i_rvalid, i_rdata[31:0], i_err      instruction completion
//     d_req, d_we, d_addr[31:0],
//     d_wdata[31:0], d_wstrb[3:0]         data request
//     d_rvalid, d_rdata[31:0], d_err      data completion
//     mem_req, mem_we, mem_addr[31:0],
//     mem_wdata[31:0], mem_wstrb[3:0]     memory request
//     mem_ready, mem_rdata[31:0]          memory response
interface mem_port_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_rvalid, i_rdata, i_err,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_rvalid, i_rdata, i_err,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 32-bit memory port between instruction fetch (read only)
//   and the data stage (read/write). Only one access is in flight at a
//   time. Data wins arbitration, but after MAX_D_STREAK consecutive data
//   grants with a fetch waiting, the next grant goes to fetch. Misaligned
//   addresses are answered locally with an error and never reach memory.
//   Every memory access is aborted with an error after TIMEOUT cycles
//   without mem_ready. All outputs are registered.
//
//   Ports:
//     clk  - clock, every register updates on posedge
//     rst  - synchronous active-high reset
//     bus  - mem_port_arbiter_if.slave carrying the i_*, d_* and mem_*
//            channels
//
//   Parameters:
//     MAX_D_STREAK - data grants allowed back to back while i_req waits
//     TIMEOUT      - cycles to wait for mem_ready before aborting
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_next;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [CNT_W-1:0]    tmo_cnt_next;

  logic                mem_req_q,   mem_req_n;
  logic                mem_we_q,    mem_we_n;
  logic [31:0]         mem_addr_q,  mem_addr_n;
  logic [31:0]         mem_wdata_q, mem_wdata_n;
  logic [3:0]          mem_wstrb_q, mem_wstrb_n;

  logic                i_rvalid_q,  i_rvalid_n;
  logic [31:0]         i_rdata_q,   i_rdata_n;
  logic                i_err_q,     i_err_n;
  logic                d_rvalid_q,  d_rvalid_n;
  logic [31:0]         d_rdata_q,   d_rdata_n;
  logic                d_err_q,     d_err_n;

  logic                d_blocked;
  logic                tmo_hit;

  // Data loses its priority only when fetch is waiting and data has
  // already used up its allowed streak.
  assign d_blocked = bus.i_req && (streak == STREAK_W'(MAX_D_STREAK));
  assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic. The completion strobes default to
  // zero so they pulse for exactly one cycle; the memory request fields
  // hold their value unless a grant or a completion changes them.
  always_comb begin
    state_next   = state;
    streak_next  = streak;
    tmo_cnt_next = tmo_cnt;

    mem_req_n    = mem_req_q;
    mem_we_n     = mem_we_q;
    mem_addr_n   = mem_addr_q;
    mem_wdata_n  = mem_wdata_q;
    mem_wstrb_n  = mem_wstrb_q;

    i_rvalid_n   = 1'b0;
    i_rdata_n    = 32'd0;
    i_err_n      = 1'b0;
    d_rvalid_n   = 1'b0;
    d_rdata_n    = 32'd0;
    d_err_n      = 1'b0;

    // Any cycle without a pending fetch ends the data streak.
    if (!bus.i_req) begin
      streak_next = '0;
    end

    case (state)
      IDLE: begin
        tmo_cnt_next = '0;
        if (bus.d_req && !d_blocked) begin
          // Below saturation here whenever i_req is high, since
          // d_blocked already covers the saturated case.
          if (bus.i_req) begin
            streak_next = streak + STREAK_W'(1);
          end
          if (bus.d_addr[1:0] != 2'b00) begin
            d_rvalid_n = 1'b1;
            d_err_n    = 1'b1;
          end else begin
            mem_req_n   = 1'b1;
            mem_we_n    = bus.d_we;
            mem_addr_n  = bus.d_addr;
            mem_wdata_n = bus.d_wdata;
            mem_wstrb_n = bus.d_we ? bus.d_wstrb : 4'b0000;
            state_next  = BUSY_D;
          end
        end else if (bus.i_req) begin
          streak_next = '0;
          if (bus.i_addr[1:0] != 2'b00) begin
            i_rvalid_n = 1'b1;
            i_err_n    = 1'b1;
          end else begin
            mem_req_n   = 1'b1;
            mem_we_n    = 1'b0;
            mem_addr_n  = bus.i_addr;
            mem_wdata_n = 32'd0;
            mem_wstrb_n = 4'b0000;
            state_next  = BUSY_I;
          end
        end
      end

      BUSY_I, BUSY_D: begin
        tmo_cnt_next = tmo_cnt + CNT_W'(1);
        // A ready in the last allowed cycle still completes normally.
        if (bus.mem_ready) begin
          mem_req_n    = 1'b0;
          tmo_cnt_next = '0;
          state_next   = IDLE;
          if (state == BUSY_D) begin
            d_rvalid_n = 1'b1;
            d_rdata_n  = mem_we_q ? 32'd0 : bus.mem_rdata;
          end else begin
            i_rvalid_n = 1'b1;
            i_rdata_n  = bus.mem_rdata;
          end
        end else if (tmo_hit) begin
          mem_req_n    = 1'b0;
          tmo_cnt_next = '0;
          state_next   = IDLE;
          if (state == BUSY_D) begin
            d_rvalid_n = 1'b1;
            d_err_n    = 1'b1;
          end else begin
            i_rvalid_n = 1'b1;
            i_err_n    = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register. Reset drops any access in flight without reporting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak      <= '0;
      tmo_cnt     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'b0000;
      i_rvalid_q  <= 1'b0;
      i_rdata_q   <= 32'd0;
      i_err_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_err_q     <= 1'b0;
    end else begin
      streak      <= streak_next;
      tmo_cnt     <= tmo_cnt_next;
      mem_req_q   <= mem_req_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      mem_wstrb_q <= mem_wstrb_n;
      i_rvalid_q  <= i_rvalid_n;
      i_rdata_q   <= i_rdata_n;
      i_err_q     <= i_err_n;
      d_rvalid_q  <= d_rvalid_n;
      d_rdata_q   <= d_rdata_n;
      d_err_q     <= d_err_n;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_err     = i_err_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;

endmodule
